// File: rtl/sc_collatz_pkg.sv
// Shared state encodings and completion status codes for the Collatz engine.
package sc_collatz_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_CHECK = 3'd1,
        ST_EVEN  = 3'd2,
        ST_ODD   = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    localparam logic [1:0] STATUS_ONE   = 2'b00;
    localparam logic [1:0] STATUS_OVF   = 2'b01;
    localparam logic [1:0] STATUS_LIMIT = 2'b10;
    localparam logic [1:0] STATUS_ZERO  = 2'b11;

endpackage

// File: rtl/sc_collatz_step.sv
// Combinational Collatz step: halved value, 3N+1 value and its overflow flag.
module sc_collatz_step #(
    parameter int DATAWIDTH = 16
) (
    input  logic [DATAWIDTH-1:0] value,
    output logic [DATAWIDTH-1:0] even_value,
    output logic [DATAWIDTH-1:0] odd_value,
    output logic                 overflow
);

    logic [DATAWIDTH+1:0] wide;
    logic [DATAWIDTH+1:0] triple;

    always_comb begin
        wide       = {2'b00, value};
        // Two guard bits hold the full 3N+1 so overflow is exact.
        triple     = (wide << 1) + wide + {{(DATAWIDTH+1){1'b0}}, 1'b1};
        even_value = value >> 1;
        odd_value  = triple[DATAWIDTH-1:0];
        overflow   = |triple[DATAWIDTH+1:DATAWIDTH];
    end

endmodule

// File: rtl/sc_collatz_engine.sv
// Runs one Collatz sequence per accepted start, reporting final value, steps, peak and status.
module sc_collatz_engine
    import sc_collatz_pkg::*;
#(
    parameter int DATAWIDTH = 16,
    parameter int STEPWIDTH = 12
) (
    input  logic                 SC_STATEMACHINE_CLOCK_50,
    input  logic                 SC_STATEMACHINE_RESET_InHigh,
    input  logic                 start_InHigh,
    input  logic [DATAWIDTH-1:0] seed_InBUS,
    input  logic [STEPWIDTH-1:0] stepLimit_InBUS,
    output logic                 busy_OutHigh,
    output logic                 done_OutHigh,
    output logic [DATAWIDTH-1:0] value_OutBUS,
    output logic [STEPWIDTH-1:0] steps_OutBUS,
    output logic [DATAWIDTH-1:0] peak_OutBUS,
    output logic [1:0]           status_OutBUS
);

    state_t               state;
    logic                 busy;
    logic                 done;
    logic [DATAWIDTH-1:0] value;
    logic [STEPWIDTH-1:0] steps;
    logic [STEPWIDTH-1:0] limit;
    logic [DATAWIDTH-1:0] peak;
    logic [1:0]           status;

    logic [DATAWIDTH-1:0] even_value;
    logic [DATAWIDTH-1:0] odd_value;
    logic                 overflow;

    sc_collatz_step #(
        .DATAWIDTH(DATAWIDTH)
    ) u_step (
        .value     (value),
        .even_value(even_value),
        .odd_value (odd_value),
        .overflow  (overflow)
    );

    always_ff @(posedge SC_STATEMACHINE_CLOCK_50 or posedge SC_STATEMACHINE_RESET_InHigh) begin
        if (SC_STATEMACHINE_RESET_InHigh) begin
            state  <= ST_IDLE;
            busy   <= 1'b0;
            done   <= 1'b0;
            value  <= '0;
            steps  <= '0;
            limit  <= '0;
            peak   <= '0;
            status <= STATUS_ONE;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start_InHigh) begin
                        value <= seed_InBUS;
                        peak  <= seed_InBUS;
                        limit <= stepLimit_InBUS;
                        steps <= '0;
                        busy  <= 1'b1;
                        state <= ST_CHECK;
                    end
                end
                ST_CHECK: begin
                    // Limit is tested before every step, so steps can never wrap.
                    if (value == '0) begin
                        status <= STATUS_ZERO;
                        done   <= 1'b1;
                        state  <= ST_DONE;
                    end else if (value == {{(DATAWIDTH-1){1'b0}}, 1'b1}) begin
                        status <= STATUS_ONE;
                        done   <= 1'b1;
                        state  <= ST_DONE;
                    end else if (steps == limit) begin
                        status <= STATUS_LIMIT;
                        done   <= 1'b1;
                        state  <= ST_DONE;
                    end else if (value[0]) begin
                        state <= ST_ODD;
                    end else begin
                        state <= ST_EVEN;
                    end
                end
                ST_EVEN: begin
                    value <= even_value;
                    steps <= steps + STEPWIDTH'(1);
                    state <= ST_CHECK;
                end
                ST_ODD: begin
                    if (overflow) begin
                        status <= STATUS_OVF;
                        done   <= 1'b1;
                        state  <= ST_DONE;
                    end else begin
                        value <= odd_value;
                        steps <= steps + STEPWIDTH'(1);
                        if (odd_value > peak) begin
                            peak <= odd_value;
                        end
                        state <= ST_CHECK;
                    end
                end
                ST_DONE: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= ST_IDLE;
                end
                default: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    assign busy_OutHigh  = busy;
    assign done_OutHigh  = done;
    assign value_OutBUS  = value;
    assign steps_OutBUS  = steps;
    assign peak_OutBUS   = peak;
    assign status_OutBUS = status;

endmodule

// File: tb/tb_sc_collatz_engine.sv
// Scoreboard bench for sc_collatz_engine at DATAWIDTH 16 and 8 with directed seeds.
module tb_sc_collatz_engine;

    localparam int E16 = 16 + 12 + 16 + 2 + 8;
    localparam int E8  = 8 + 12 + 8 + 2 + 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic        start16 = 1'b0;
    logic [15:0] seed16  = '0;
    logic [11:0] limit16 = '0;
    logic        busy16, done16;
    logic [15:0] value16, peak16;
    logic [11:0] steps16;
    logic [1:0]  status16;

    logic        start8 = 1'b0;
    logic [7:0]  seed8  = '0;
    logic [11:0] limit8 = '0;
    logic        busy8, done8;
    logic [7:0]  value8, peak8;
    logic [11:0] steps8;
    logic [1:0]  status8;

    sc_collatz_engine #(.DATAWIDTH(16), .STEPWIDTH(12)) u_dut16 (
        .SC_STATEMACHINE_CLOCK_50    (clk),
        .SC_STATEMACHINE_RESET_InHigh(rst),
        .start_InHigh                (start16),
        .seed_InBUS                  (seed16),
        .stepLimit_InBUS             (limit16),
        .busy_OutHigh                (busy16),
        .done_OutHigh                (done16),
        .value_OutBUS                (value16),
        .steps_OutBUS                (steps16),
        .peak_OutBUS                 (peak16),
        .status_OutBUS               (status16)
    );

    sc_collatz_engine #(.DATAWIDTH(8), .STEPWIDTH(12)) u_dut8 (
        .SC_STATEMACHINE_CLOCK_50    (clk),
        .SC_STATEMACHINE_RESET_InHigh(rst),
        .start_InHigh                (start8),
        .seed_InBUS                  (seed8),
        .stepLimit_InBUS             (limit8),
        .busy_OutHigh                (busy8),
        .done_OutHigh                (done8),
        .value_OutBUS                (value8),
        .steps_OutBUS                (steps8),
        .peak_OutBUS                 (peak8),
        .status_OutBUS               (status8)
    );

    // Expected entries are packed {value, steps, peak, status, cycles from start}.
    logic [E16-1:0] exp16_q[$];
    logic [E8-1:0]  exp8_q[$];
    int pass_cnt  = 0;
    int total_cnt = 0;
    int cyc16 = 0;
    int cyc8  = 0;

    task automatic chk(input string name, input longint act, input longint req);
        total_cnt++;
        if (act == req) pass_cnt++;
        else $display("FAIL %s: got %0d expected %0d", name, act, req);
    endtask

    // Monitors: count cycles since acceptance and score every done pulse.
    always @(negedge clk) begin
        logic [E16-1:0] e;
        if (rst || !busy16) cyc16 = 0;
        else cyc16++;
        if (!rst && done16) begin
            if (exp16_q.size() == 0) begin
                chk("dut16_unexpected_done", 1, 0);
            end else begin
                e = exp16_q.pop_front();
                chk("dut16_value",   value16,  e[53:38]);
                chk("dut16_steps",   steps16,  e[37:26]);
                chk("dut16_peak",    peak16,   e[25:10]);
                chk("dut16_status",  status16, e[9:8]);
                chk("dut16_latency", cyc16,    e[7:0]);
            end
        end
    end

    always @(negedge clk) begin
        logic [E8-1:0] e;
        if (rst || !busy8) cyc8 = 0;
        else cyc8++;
        if (!rst && done8) begin
            if (exp8_q.size() == 0) begin
                chk("dut8_unexpected_done", 1, 0);
            end else begin
                e = exp8_q.pop_front();
                chk("dut8_value",   value8,  e[37:30]);
                chk("dut8_steps",   steps8,  e[29:18]);
                chk("dut8_peak",    peak8,   e[17:10]);
                chk("dut8_status",  status8, e[9:8]);
                chk("dut8_latency", cyc8,    e[7:0]);
            end
        end
    end

    task automatic wait_idle16();
        int n = 0;
        while ((busy16 || exp16_q.size() != 0) && n < 2000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 2000) chk("dut16_idle_timeout", 1, 0);
    endtask

    task automatic wait_idle8();
        int n = 0;
        while ((busy8 || exp8_q.size() != 0) && n < 2000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 2000) chk("dut8_idle_timeout", 1, 0);
    endtask

    task automatic go16(input logic [15:0] s, input logic [11:0] l,
                        input logic [15:0] ev, input logic [11:0] es, input logic [15:0] ep,
                        input logic [1:0] est, input logic [7:0] lat);
        wait_idle16();
        exp16_q.push_back({ev, es, ep, est, lat});
        seed16  = s;
        limit16 = l;
        start16 = 1'b1;
        @(negedge clk);
        start16 = 1'b0;
    endtask

    task automatic go8(input logic [7:0] s, input logic [11:0] l,
                       input logic [7:0] ev, input logic [11:0] es, input logic [7:0] ep,
                       input logic [1:0] est, input logic [7:0] lat);
        wait_idle8();
        exp8_q.push_back({ev, es, ep, est, lat});
        seed8  = s;
        limit8 = l;
        start8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0;
    endtask

    task automatic chk_zero16(input string tag);
        chk({tag, "_busy16"},   busy16,   0);
        chk({tag, "_done16"},   done16,   0);
        chk({tag, "_value16"},  value16,  0);
        chk({tag, "_steps16"},  steps16,  0);
        chk({tag, "_peak16"},   peak16,   0);
        chk({tag, "_status16"}, status16, 0);
    endtask

    initial begin
        int n;
        repeat (3) @(negedge clk);
        chk_zero16("reset");
        chk("reset_busy8",  busy8,  0);
        chk("reset_done8",  done8,  0);
        chk("reset_value8", value8, 0);
        chk("reset_peak8",  peak8,  0);
        rst = 1'b0;
        @(negedge clk);

        go8(8'd27, 12'd100, 8'd107, 12'd11, 8'd214, 2'b01, 8'd25);
        go16(16'd6, 12'd100, 16'd1, 12'd8, 16'd16, 2'b00, 8'd18);
        wait_idle16();
        repeat (3) @(negedge clk);
        chk("hold_value16",  value16,  1);
        chk("hold_steps16",  steps16,  8);
        chk("hold_peak16",   peak16,   16);
        chk("hold_status16", status16, 0);

        // A start pulse mid-run must not disturb the sequence in flight.
        go16(16'd6, 12'd100, 16'd1, 12'd8, 16'd16, 2'b00, 8'd18);
        repeat (4) @(negedge clk);
        seed16  = 16'd1;
        limit16 = 12'd0;
        start16 = 1'b1;
        @(negedge clk);
        start16 = 1'b0;

        go16(16'd27, 12'd5, 16'd31, 12'd5, 16'd124, 2'b10, 8'd12);
        go16(16'd0, 12'd100, 16'd0, 12'd0, 16'd0, 2'b11, 8'd2);
        go16(16'd1, 12'd100, 16'd1, 12'd0, 16'd1, 2'b00, 8'd2);
        go8(8'd6, 12'd100, 8'd1, 12'd8, 8'd16, 2'b00, 8'd18);

        // Start held through the done cycle is taken on the following idle cycle only.
        go16(16'd6, 12'd2, 16'd10, 12'd2, 16'd10, 2'b10, 8'd6);
        n = 0;
        while (!done16 && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("dut16_done_seen", done16, 1);
        exp16_q.push_back({16'd0, 12'd0, 16'd0, 2'b11, 8'd2});
        seed16  = 16'd0;
        limit16 = 12'd100;
        start16 = 1'b1;
        @(negedge clk);
        @(negedge clk);
        start16 = 1'b0;
        wait_idle16();
        wait_idle8();

        // Reset in the middle of a long run aborts with no done pulse.
        seed16  = 16'd27;
        limit16 = 12'd100;
        start16 = 1'b1;
        @(negedge clk);
        start16 = 1'b0;
        repeat (10) @(negedge clk);
        chk("midrun_busy", busy16, 1);
        rst = 1'b1;
        #1;
        chk_zero16("midrun_reset");
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (20) @(negedge clk);
        chk("midrun_idle_busy", busy16, 0);

        chk("dut16_queue_empty", exp16_q.size(), 0);
        chk("dut8_queue_empty",  exp8_q.size(),  0);
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/sc_collatz_engine.md
SC_COLLATZ_ENGINE -- requirements
Module: sc_collatz_engine

Interface
REQ-001 SHALL have parameter DATAWIDTH, default 16, setting the width of the Collatz value.
REQ-002 SHALL have parameter STEPWIDTH, default 12, setting the width of the step counter and step limit.
REQ-003 SHALL have port SC_STATEMACHINE_CLOCK_50, input, 1 bit: clock, rising edge.
REQ-004 SHALL have port SC_STATEMACHINE_RESET_InHigh, input, 1 bit: reset, asynchronous, active-high.
REQ-005 SHALL have port start_InHigh, input, 1 bit: request to run one sequence.
REQ-006 SHALL have port seed_InBUS, input, DATAWIDTH bits: starting value N.
REQ-007 SHALL have port stepLimit_InBUS, input, STEPWIDTH bits: maximum number of steps allowed.
REQ-008 SHALL have port busy_OutHigh, output, 1 bit: high while a sequence runs.
REQ-009 SHALL have port done_OutHigh, output, 1 bit: one-cycle pulse when a sequence completes.
REQ-010 SHALL have port value_OutBUS, output, DATAWIDTH bits: current or final value.
REQ-011 SHALL have port steps_OutBUS, output, STEPWIDTH bits: number of steps executed.
REQ-012 SHALL have port peak_OutBUS, output, DATAWIDTH bits: maximum value reached so far.
REQ-013 SHALL have port status_OutBUS, output, 2 bits: 00 reached 1; 01 overflow; 10 step limit; 11 zero seed.

Function
REQ-014 SHALL implement the states IDLE, CHECK, EVEN, ODD and DONE.
REQ-015 SHALL, in IDLE with start_InHigh=1, capture the seed into the value and peak registers, load the limit, clear steps, and enter CHECK on the next cycle.
REQ-016 SHALL, in CHECK, test in priority order:
- value==0 -> status 11 -> DONE
- value==1 -> status 00 -> DONE
- steps==limit -> status 10 -> DONE
- otherwise value[0]=0 -> EVEN, value[0]=1 -> ODD
REQ-017 SHALL, in EVEN, set value <= value>>1 and steps <= steps+1, then return to CHECK.
REQ-018 SHALL, in ODD, compute 3N+1 at DATAWIDTH+2 bits.
REQ-019 SHALL, in ODD, treat any nonzero upper 2 bits as overflow: status 01 -> DONE, with value, steps and peak unchanged.
REQ-020 SHALL, in ODD without overflow, set value <= 3N+1, increment steps, set peak <= max(peak, 3N+1), and return to CHECK.
REQ-021 SHALL, in DONE, assert done_OutHigh for exactly one cycle and then return to IDLE.
REQ-022 SHALL hold busy_OutHigh high in CHECK, EVEN, ODD and DONE, and low in IDLE.
REQ-023 SHALL produce the DONE cycle 2*S+2 cycles after the start sample, where S is the final step count (non-overflow cases).
REQ-024 SHALL ignore start_InHigh while busy; the seed and limit inputs are sampled only at acceptance.
REQ-025 SHALL hold value, steps, peak and status stable from DONE until the next accepted start.
REQ-026 SHALL accept start_InHigh asserted in the same cycle as done_OutHigh only on the following IDLE cycle.
REQ-027 SHALL never let the step counter wrap, because the limit check precedes every step.

Reset
REQ-028 SHALL, on reset, clear state to IDLE and drive busy=0, done=0, value=0, steps=0, peak=0 and status=00.
REQ-029 SHALL, on reset asserted mid-sequence, abort immediately with no done pulse.

Structure
REQ-030 SHALL place the state encodings and the status codes in the shared package sc_collatz_pkg.
REQ-031 SHALL use one combinational sub-module, sc_collatz_step, producing next even value, next odd value and the overflow flag.

Verification
REQ-032 SHALL cover: DATAWIDTH=16, seed 6, limit 100 -> done at cycle 18 after start, value 1, steps 8, peak 16, status 00.
REQ-033 SHALL cover: DATAWIDTH=8, seed 27, limit 100 -> status 01, value 107, steps 11, peak 214.
REQ-034 SHALL cover: DATAWIDTH=16, seed 27, limit 5 -> status 10, value 31, steps 5, peak 124.
REQ-035 SHALL cover: seed 0 -> status 11, steps 0, done at cycle 2; seed 1 -> status 00, steps 0, done at cycle 2.
REQ-036 SHALL cover: start pulsed while busy -> ignored and results unchanged; reset mid-run -> IDLE, all outputs 0, no done pulse.
